// File: rtl/line_mem_responder_pkg.sv
// Shared types and constants for the line-granular memory responder.
// The line type uses the default geometry; modules size their own lines from their parameters.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int LAT_CNT_W         = 8;
    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_LINE_SIZE     = 2 ** DEF_LINE_ADDR_LEN;

    typedef logic [DEF_LINE_SIZE-1:0][31:0] line_t;

endpackage

// File: rtl/line_mem_responder_if.sv
// Request/response bundle between a cache controller (master) and the line memory (slave).
interface line_mem_responder_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9
);
    localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN;

    logic [ADDR_LEN-1:0]        addr;
    logic                       rd_req;
    logic                       wr_req;
    logic [LINE_SIZE-1:0][31:0] wr_line;
    logic [LINE_SIZE-1:0][31:0] rd_line;
    logic                       gnt;
    logic [31:0]                rd_count;
    logic [31:0]                wr_count;

    modport master (
        output addr, rd_req, wr_req, wr_line,
        input  rd_line, gnt, rd_count, wr_count
    );

    modport slave (
        input  addr, rd_req, wr_req, wr_line,
        output rd_line, gnt, rd_count, wr_count
    );
endinterface

// File: rtl/line_mem_array.sv
// Line storage: whole-line synchronous write port and combinational read port.
module line_mem_array #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9
) (
    input  logic                                   clk,
    input  logic                                   i_we,
    input  logic [ADDR_LEN-1:0]                    i_wrAddr,
    input  logic [(2**LINE_ADDR_LEN)-1:0][31:0]    i_wrLine,
    input  logic [ADDR_LEN-1:0]                    i_rdAddr,
    output logic [(2**LINE_ADDR_LEN)-1:0][31:0]    o_rdLine
);
    localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN;
    localparam int DEPTH     = 2 ** ADDR_LEN;

    // Contents are deliberately not reset.
    logic [LINE_SIZE-1:0][31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wrAddr] <= i_wrLine;
        end
    end

    assign o_rdLine = r_mem[i_rdAddr];

endmodule

// File: rtl/line_mem_responder.sv
// Line memory responder: accepts one held request, waits LATENCY cycles, pulses gnt.
// Writes commit on the edge leaving DONE; reads load rd_line on the edge entering DONE.
module line_mem_responder
    import mem_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int LATENCY       = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    line_mem_responder_if.slave  bus
);
    localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN;
    localparam logic [LAT_CNT_W-1:0] LOAD_VAL =
        (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;

    state_t                     r_state, w_nextState;
    logic [LAT_CNT_W-1:0]       r_cnt, w_nextCnt;
    logic                       w_accept;
    logic [ADDR_LEN-1:0]        r_addr;
    logic                       r_isWr;
    logic [LINE_SIZE-1:0][31:0] r_wrLine;
    logic [LINE_SIZE-1:0][31:0] r_rdLine;
    logic [31:0]                r_rdCount;
    logic [31:0]                r_wrCount;
    logic                       w_curWr;
    logic [ADDR_LEN-1:0]        w_rdAddr;
    logic                       w_loadRd;
    logic                       w_commit;
    logic [LINE_SIZE-1:0][31:0] w_arrLine;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.rd_req || bus.wr_req) begin
                    w_accept    = 1'b1;
                    w_nextState = (LATENCY == 1) ? DONE : BUSY;
                    w_nextCnt   = LOAD_VAL;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_nextState = DONE;
                end else begin
                    w_nextCnt = r_cnt - LAT_CNT_W'(1);
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // With LATENCY==1 the access enters DONE on the accept edge, so use live inputs there.
    assign w_curWr  = (r_state == IDLE) ? bus.wr_req : r_isWr;
    assign w_rdAddr = (r_state == IDLE) ? bus.addr   : r_addr;
    assign w_loadRd = (w_nextState == DONE) && (r_state != DONE) && !w_curWr;
    assign w_commit = (r_state == DONE) && r_isWr;

    line_mem_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .ADDR_LEN      (ADDR_LEN)
    ) u_array (
        .clk      (clk),
        .i_we     (w_commit),
        .i_wrAddr (r_addr),
        .i_wrLine (r_wrLine),
        .i_rdAddr (w_rdAddr),
        .o_rdLine (w_arrLine)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_isWr    <= 1'b0;
            r_wrLine  <= '0;
            r_rdLine  <= '0;
            r_rdCount <= '0;
            r_wrCount <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_accept) begin
                r_addr   <= bus.addr;
                r_isWr   <= bus.wr_req;
                r_wrLine <= bus.wr_line;
            end
            if (w_loadRd) begin
                r_rdLine <= w_arrLine;
            end
            if (r_state == DONE) begin
                if (r_isWr) begin
                    r_wrCount <= r_wrCount + 32'd1;
                end else begin
                    r_rdCount <= r_rdCount + 32'd1;
                end
            end
        end
    end

    assign bus.gnt      = (r_state == DONE);
    assign bus.rd_line  = r_rdLine;
    assign bus.rd_count = r_rdCount;
    assign bus.wr_count = r_wrCount;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a LATENCY=4 instance for the main scenarios
// and a LATENCY=1 instance for the short-latency path.
module tb_line_mem_responder;
    import mem_pkg::*;

    logic clk;
    logic rst_n;
    int   errCnt;
    int   chkCnt;
    int   expRd;
    int   expWr;

    line_mem_responder_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(9)) ifA ();
    line_mem_responder_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(9)) ifB ();

    line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(4)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA.slave)
    );

    line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(1)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic line_t mkLine(input logic [31:0] base);
        line_t l;
        for (int i = 0; i < DEF_LINE_SIZE; i++) l[i] = base + 32'(i);
        return l;
    endfunction

    // Drives one access on the LATENCY=4 instance and scrambles addr/data after acceptance.
    task automatic runOp(input logic wr, input logic rd, input logic [8:0] a, input line_t d,
                         output int cyc, output line_t rdDuring, output logic gntNext);
        logic got;
        ifA.wr_req = wr; ifA.rd_req = rd; ifA.addr = a; ifA.wr_line = d;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            got = ifA.gnt;
            if (!got) begin
                ifA.addr = ~a;
                ifA.wr_line = ~d;
            end
        end
        rdDuring = ifA.rd_line;
        ifA.wr_req = 1'b0; ifA.rd_req = 1'b0; ifA.addr = '0; ifA.wr_line = '0;
        @(posedge clk); #1;
        gntNext = ifA.gnt;
    endtask

    task automatic runOpB(input logic wr, input logic [8:0] a, input line_t d,
                          output int cyc, output logic gntNext);
        logic got;
        ifB.wr_req = wr; ifB.rd_req = ~wr; ifB.addr = a; ifB.wr_line = d;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            got = ifB.gnt;
        end
        ifB.wr_req = 1'b0; ifB.rd_req = 1'b0; ifB.addr = '0; ifB.wr_line = '0;
        @(posedge clk); #1;
        gntNext = ifB.gnt;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        chkCnt++; if (ifA.gnt !== 1'b0) begin errCnt++; $display("[TB] FAIL reset_gnt: got %b expected 0", ifA.gnt); end
        chkCnt++; if (ifA.rd_line !== '0) begin errCnt++; $display("[TB] FAIL reset_rd_line: got %h expected 0", ifA.rd_line); end
        chkCnt++; if (ifA.rd_count !== 32'd0) begin errCnt++; $display("[TB] FAIL reset_rd_count: got %0d expected 0", ifA.rd_count); end
        chkCnt++; if (ifA.wr_count !== 32'd0) begin errCnt++; $display("[TB] FAIL reset_wr_count: got %0d expected 0", ifA.wr_count); end
        chkCnt++; if (ifB.gnt !== 1'b0) begin errCnt++; $display("[TB] FAIL reset_gnt_b: got %b expected 0", ifB.gnt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int    cyc;
        line_t rdD;
        logic  gn;
        logic  sawGnt;
        runOp(1'b1, 1'b0, 9'd5, mkLine(32'h5555_0000), cyc, rdD, gn);
        chkCnt++; if (cyc !== 4) begin errCnt++; $display("[TB] FAIL abort_prewrite_latency: got %0d expected 4", cyc); end
        rst_n = 1'b0; #2; rst_n = 1'b1;
        chkCnt++; if (ifA.wr_count !== 32'd0) begin errCnt++; $display("[TB] FAIL abort_count_cleared: got %0d expected 0", ifA.wr_count); end
        ifA.wr_req = 1'b1; ifA.addr = 9'd5; ifA.wr_line = mkLine(32'hA5A5_0000);
        sawGnt = 1'b0;
        repeat (2) begin @(posedge clk); #1; sawGnt |= ifA.gnt; end
        rst_n = 1'b0; #2;
        ifA.wr_req = 1'b0; ifA.addr = '0; ifA.wr_line = '0;
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; sawGnt |= ifA.gnt; end
        chkCnt++; if (sawGnt !== 1'b0) begin errCnt++; $display("[TB] FAIL abort_no_gnt: got %b expected 0", sawGnt); end
        chkCnt++; if (ifA.wr_count !== 32'd0) begin errCnt++; $display("[TB] FAIL abort_wr_count: got %0d expected 0", ifA.wr_count); end
        runOp(1'b0, 1'b1, 9'd5, '0, cyc, rdD, gn);
        chkCnt++; if (rdD !== mkLine(32'h5555_0000)) begin errCnt++; $display("[TB] FAIL abort_prior_data: got %h expected %h", rdD, mkLine(32'h5555_0000)); end
        chkCnt++; if (ifA.rd_count !== 32'd1) begin errCnt++; $display("[TB] FAIL abort_rd_count: got %0d expected 1", ifA.rd_count); end
    endtask

    task automatic test_write_read();
        int    cyc;
        line_t rdD;
        logic  gn;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        runOp(1'b1, 1'b0, 9'h012, mkLine(32'h1000), cyc, rdD, gn);
        chkCnt++; if (cyc !== 4) begin errCnt++; $display("[TB] FAIL wr_latency: got %0d expected 4", cyc); end
        chkCnt++; if (gn !== 1'b0) begin errCnt++; $display("[TB] FAIL wr_gnt_width: got %b expected 0", gn); end
        chkCnt++; if (ifA.wr_count !== 32'd1) begin errCnt++; $display("[TB] FAIL wr_count_one: got %0d expected 1", ifA.wr_count); end
        chkCnt++; if (ifA.rd_count !== 32'd0) begin errCnt++; $display("[TB] FAIL wr_rd_count_zero: got %0d expected 0", ifA.rd_count); end
        runOp(1'b0, 1'b1, 9'h012, '0, cyc, rdD, gn);
        chkCnt++; if (cyc !== 4) begin errCnt++; $display("[TB] FAIL rd_latency: got %0d expected 4", cyc); end
        chkCnt++; if (gn !== 1'b0) begin errCnt++; $display("[TB] FAIL rd_gnt_width: got %b expected 0", gn); end
        chkCnt++; if (rdD !== mkLine(32'h1000)) begin errCnt++; $display("[TB] FAIL rd_data_during_gnt: got %h expected %h", rdD, mkLine(32'h1000)); end
        repeat (3) @(posedge clk); #1;
        chkCnt++; if (ifA.rd_line !== mkLine(32'h1000)) begin errCnt++; $display("[TB] FAIL rd_data_after_gnt: got %h expected %h", ifA.rd_line, mkLine(32'h1000)); end
        chkCnt++; if (ifA.rd_count !== 32'd1) begin errCnt++; $display("[TB] FAIL rd_count_one: got %0d expected 1", ifA.rd_count); end
        chkCnt++; if (ifA.wr_count !== 32'd1) begin errCnt++; $display("[TB] FAIL rd_wr_count_one: got %0d expected 1", ifA.wr_count); end
        expRd = 1; expWr = 1;
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic got;
        ifA.wr_req = 1'b1; ifA.addr = 9'd3; ifA.wr_line = mkLine(32'h3000);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 50) begin @(posedge clk); #1; cyc++; got = ifA.gnt; end
        chkCnt++; if (cyc !== 4) begin errCnt++; $display("[TB] FAIL b2b_wr_latency: got %0d expected 4", cyc); end
        ifA.wr_req = 1'b0; ifA.rd_req = 1'b1; ifA.addr = 9'd3; ifA.wr_line = '0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 50) begin @(posedge clk); #1; cyc++; got = ifA.gnt; end
        chkCnt++; if (cyc !== 5) begin errCnt++; $display("[TB] FAIL b2b_rd_latency: got %0d expected 5", cyc); end
        chkCnt++; if (ifA.rd_line !== mkLine(32'h3000)) begin errCnt++; $display("[TB] FAIL b2b_rd_data: got %h expected %h", ifA.rd_line, mkLine(32'h3000)); end
        ifA.rd_req = 1'b0; ifA.addr = '0;
        @(posedge clk); #1;
        expWr++; expRd++;
        chkCnt++; if (ifA.wr_count !== 32'(expWr)) begin errCnt++; $display("[TB] FAIL b2b_wr_count: got %0d expected %0d", ifA.wr_count, expWr); end
        chkCnt++; if (ifA.rd_count !== 32'(expRd)) begin errCnt++; $display("[TB] FAIL b2b_rd_count: got %0d expected %0d", ifA.rd_count, expRd); end
    endtask

    task automatic test_hold();
        int    cyc;
        line_t rdD;
        logic  gn;
        runOp(1'b1, 1'b0, 9'd7, mkLine(32'h7000), cyc, rdD, gn);
        runOp(1'b0, 1'b1, 9'd7, '0, cyc, rdD, gn);
        chkCnt++; if (rdD !== mkLine(32'h7000)) begin errCnt++; $display("[TB] FAIL hold_first_read: got %h expected %h", rdD, mkLine(32'h7000)); end
        runOp(1'b1, 1'b0, 9'd7, mkLine(32'h7700), cyc, rdD, gn);
        chkCnt++; if (rdD !== mkLine(32'h7000)) begin errCnt++; $display("[TB] FAIL hold_during_write: got %h expected %h", rdD, mkLine(32'h7000)); end
        repeat (3) @(posedge clk); #1;
        chkCnt++; if (ifA.rd_line !== mkLine(32'h7000)) begin errCnt++; $display("[TB] FAIL hold_after_write: got %h expected %h", ifA.rd_line, mkLine(32'h7000)); end
        runOp(1'b0, 1'b1, 9'd7, '0, cyc, rdD, gn);
        chkCnt++; if (rdD !== mkLine(32'h7700)) begin errCnt++; $display("[TB] FAIL hold_second_read: got %h expected %h", rdD, mkLine(32'h7700)); end
        expWr += 2; expRd += 2;
    endtask

    task automatic test_simultaneous();
        int    cyc;
        line_t rdD;
        logic  gn;
        runOp(1'b1, 1'b1, 9'd2, mkLine(32'h2200), cyc, rdD, gn);
        expWr++;
        chkCnt++; if (ifA.wr_count !== 32'(expWr)) begin errCnt++; $display("[TB] FAIL simul_wr_count: got %0d expected %0d", ifA.wr_count, expWr); end
        chkCnt++; if (ifA.rd_count !== 32'(expRd)) begin errCnt++; $display("[TB] FAIL simul_rd_count: got %0d expected %0d", ifA.rd_count, expRd); end
        chkCnt++; if (ifA.rd_line !== mkLine(32'h7700)) begin errCnt++; $display("[TB] FAIL simul_rd_line_held: got %h expected %h", ifA.rd_line, mkLine(32'h7700)); end
        runOp(1'b0, 1'b1, 9'd2, '0, cyc, rdD, gn);
        chkCnt++; if (rdD !== mkLine(32'h2200)) begin errCnt++; $display("[TB] FAIL simul_readback: got %h expected %h", rdD, mkLine(32'h2200)); end
    endtask

    task automatic test_latency_one();
        int   cyc;
        logic gn;
        runOpB(1'b1, 9'd1, mkLine(32'h0100), cyc, gn);
        chkCnt++; if (cyc !== 1) begin errCnt++; $display("[TB] FAIL lat1_wr_latency: got %0d expected 1", cyc); end
        chkCnt++; if (gn !== 1'b0) begin errCnt++; $display("[TB] FAIL lat1_wr_gnt_width: got %b expected 0", gn); end
        runOpB(1'b0, 9'd1, '0, cyc, gn);
        chkCnt++; if (cyc !== 1) begin errCnt++; $display("[TB] FAIL lat1_rd_latency: got %0d expected 1", cyc); end
        chkCnt++; if (ifB.rd_line !== mkLine(32'h0100)) begin errCnt++; $display("[TB] FAIL lat1_rd_data: got %h expected %h", ifB.rd_line, mkLine(32'h0100)); end
        chkCnt++; if (ifB.rd_count !== 32'd1) begin errCnt++; $display("[TB] FAIL lat1_rd_count: got %0d expected 1", ifB.rd_count); end
        chkCnt++; if (ifB.wr_count !== 32'd1) begin errCnt++; $display("[TB] FAIL lat1_wr_count: got %0d expected 1", ifB.wr_count); end
    endtask

    initial begin
        errCnt = 0; chkCnt = 0; expRd = 0; expWr = 0;
        rst_n = 1'b0;
        ifA.rd_req = 1'b0; ifA.wr_req = 1'b0; ifA.addr = '0; ifA.wr_line = '0;
        ifB.rd_req = 1'b0; ifB.wr_req = 1'b0; ifB.addr = '0; ifB.wr_line = '0;
        test_reset();
        test_abort();
        test_write_read();
        test_back_to_back();
        test_hold();
        test_simultaneous();
        test_latency_one();
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
